// File: rtl/uart_link_ctrl.sv
// Frame controller for the game-link UART: round-robin TX framing (5-byte frames, ack one cycle after the last write)
// and RX frame hunt/check (rx_valid one cycle after CHK pop); tx_full stalls TX byte-for-byte, RX pops whenever data is present.
module uart_link_ctrl #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ID_SCORE       = 8'h01,
  parameter logic [7:0]  ID_PADDLE      = 8'h02,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_score,
  input  logic [15:0] score_data,
  output logic        ack_score,
  input  logic        req_paddle,
  input  logic [15:0] paddle_data,
  output logic        ack_paddle,
  input  logic        tx_full,
  output logic        wr_uart,
  output logic [7:0]  wr_data,
  input  logic        rx_empty,
  input  logic [7:0]  rd_data,
  output logic        rd_uart,
  output logic        rx_valid,
  output logic [7:0]  rx_id,
  output logic [15:0] rx_payload,
  output logic [7:0]  err_cnt
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_DONE} tx_state_t;
  typedef enum logic [2:0] {RX_HUNT, RX_GET_ID, RX_GET_D0, RX_GET_D1, RX_GET_CHK} rx_state_t;

  tx_state_t   r_tx_state, w_tx_nxt;
  logic [2:0]  r_idx;
  logic [7:0]  r_tx_id;
  logic [15:0] r_tx_data;
  logic        r_gnt_pad;
  logic        r_pref_pad;
  logic        w_grant, w_grant_pad, w_wr;
  logic [7:0]  w_byte;

  always_comb begin
    w_tx_nxt    = r_tx_state;
    w_grant     = 1'b0;
    w_grant_pad = 1'b0;
    w_wr        = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (req_score || req_paddle) begin
          w_grant     = 1'b1;
          w_grant_pad = req_paddle && (!req_score || r_pref_pad);
          w_tx_nxt    = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!tx_full) begin
          w_wr = 1'b1;
          if (r_idx == 3'd4) w_tx_nxt = TX_DONE;
        end
      end
      default: w_tx_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      3'd0:    w_byte = SYNC_BYTE;
      3'd1:    w_byte = r_tx_id;
      3'd2:    w_byte = r_tx_data[15:8];
      3'd3:    w_byte = r_tx_data[7:0];
      default: w_byte = r_tx_id ^ r_tx_data[15:8] ^ r_tx_data[7:0];
    endcase
  end

  assign wr_uart    = w_wr;
  assign wr_data    = w_wr ? w_byte : 8'h00;
  assign ack_score  = (r_tx_state == TX_DONE) && !r_gnt_pad;
  assign ack_paddle = (r_tx_state == TX_DONE) && r_gnt_pad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state <= TX_IDLE;
      r_idx      <= 3'd0;
      r_tx_id    <= 8'h00;
      r_tx_data  <= 16'h0000;
      r_gnt_pad  <= 1'b0;
      r_pref_pad <= 1'b0;
    end else begin
      r_tx_state <= w_tx_nxt;
      if (w_grant) begin
        r_gnt_pad <= w_grant_pad;
        r_tx_id   <= w_grant_pad ? ID_PADDLE : ID_SCORE;
        r_tx_data <= w_grant_pad ? paddle_data : score_data;
        r_idx     <= 3'd0;
      end else if (w_wr) begin
        r_idx <= r_idx + 3'd1;
      end
      // Next tie goes to whoever was not just served.
      if (r_tx_state == TX_DONE) r_pref_pad <= !r_gnt_pad;
    end
  end

  rx_state_t       r_rx_state, w_rx_nxt;
  logic [7:0]      r_fid, r_d0, r_d1;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_err_cnt;
  logic            r_rx_valid;
  logic [7:0]      r_rx_id;
  logic [15:0]     r_rx_payload;
  logic            w_pop, w_chk_ok, w_chk_bad, w_timeout;

  // Gated by reset so the pop strobe is also low while the block is held in reset.
  assign w_pop = reset_n && !rx_empty;

  always_comb begin
    w_rx_nxt  = r_rx_state;
    w_chk_ok  = 1'b0;
    w_chk_bad = 1'b0;
    w_timeout = 1'b0;
    if (r_rx_state == RX_HUNT) begin
      if (w_pop && rd_data == SYNC_BYTE) w_rx_nxt = RX_GET_ID;
    end else if (w_pop) begin
      case (r_rx_state)
        RX_GET_ID: w_rx_nxt = RX_GET_D0;
        RX_GET_D0: w_rx_nxt = RX_GET_D1;
        RX_GET_D1: w_rx_nxt = RX_GET_CHK;
        default: begin
          w_rx_nxt = RX_HUNT;
          if (rd_data == (r_fid ^ r_d0 ^ r_d1)) w_chk_ok  = 1'b1;
          else                                  w_chk_bad = 1'b1;
        end
      endcase
    end else if (r_to_cnt == TO_LAST) begin
      w_timeout = 1'b1;
      w_rx_nxt  = RX_HUNT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state   <= RX_HUNT;
      r_fid        <= 8'h00;
      r_d0         <= 8'h00;
      r_d1         <= 8'h00;
      r_to_cnt     <= '0;
      r_err_cnt    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_rx_id      <= 8'h00;
      r_rx_payload <= 16'h0000;
    end else begin
      r_rx_state <= w_rx_nxt;
      r_rx_valid <= w_chk_ok;
      if (w_chk_ok) begin
        r_rx_id      <= r_fid;
        r_rx_payload <= {r_d0, r_d1};
      end
      if (w_pop) begin
        case (r_rx_state)
          RX_GET_ID: r_fid <= rd_data;
          RX_GET_D0: r_d0  <= rd_data;
          RX_GET_D1: r_d1  <= rd_data;
          default:   ;
        endcase
      end
      if (w_pop || w_timeout || r_rx_state == RX_HUNT) r_to_cnt <= '0;
      else                                             r_to_cnt <= r_to_cnt + 1'b1;
      if ((w_chk_bad || w_timeout) && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign rd_uart    = w_pop;
  assign rx_valid   = r_rx_valid;
  assign rx_id      = r_rx_id;
  assign rx_payload = r_rx_payload;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Cycle-exact vector tables for the TX arbiter/framer and RX decoder, plus hand sequences
// for error-counter saturation and reset in the middle of a TX frame.
module tb_uart_link_ctrl;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_score, req_paddle, tx_full, rx_empty;
  logic [15:0] score_data, paddle_data;
  logic [7:0]  rd_data;
  logic        ack_score, ack_paddle, wr_uart, rd_uart, rx_valid;
  logic [7:0]  wr_data, rx_id, err_cnt;
  logic [15:0] rx_payload;

  int n_vec = 0;
  int n_bad = 0;

  uart_link_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_score(req_score), .score_data(score_data), .ack_score(ack_score),
    .req_paddle(req_paddle), .paddle_data(paddle_data), .ack_paddle(ack_paddle),
    .tx_full(tx_full), .wr_uart(wr_uart), .wr_data(wr_data),
    .rx_empty(rx_empty), .rd_data(rd_data), .rd_uart(rd_uart),
    .rx_valid(rx_valid), .rx_id(rx_id), .rx_payload(rx_payload), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rs, rp, txf, ew;
    logic [7:0] ed;
    logic eas, eap;
  } tx_vec_t;

  typedef struct packed {
    logic emp;
    logic [7:0] dat;
    logic erd, ev;
    logic [7:0] eid;
    logic [15:0] epay;
    logic [7:0] eerr;
  } rx_vec_t;

  tx_vec_t tx_tab[$];
  rx_vec_t rx_tab[$];

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vector %0d): got %h, expected %h", nm, n_vec, act, exp);
    end
  endtask

  task automatic tx_cycle(input string nm, input logic rs, input logic rp, input logic txf,
                          input logic ew, input logic [7:0] ed, input logic eas, input logic eap);
    @(negedge clk);
    req_score = rs; req_paddle = rp; tx_full = txf;
    #1;
    check(nm, 40'({wr_uart, wr_data, ack_score, ack_paddle}), 40'({ew, ed, eas, eap}));
  endtask

  task automatic rx_cycle(input string nm, input logic emp, input logic [7:0] dat, input logic erd,
                          input logic ev, input logic [7:0] eid, input logic [15:0] epay,
                          input logic [7:0] eerr);
    @(negedge clk);
    rx_empty = emp; rd_data = dat;
    #1;
    check(nm, 40'({rd_uart, rx_valid, rx_id, rx_payload, err_cnt}), 40'({erd, ev, eid, epay, eerr}));
  endtask

  task automatic add_tx(input logic rs, input logic rp, input logic txf, input logic ew,
                        input logic [7:0] ed, input logic eas, input logic eap);
    tx_tab.push_back('{rs, rp, txf, ew, ed, eas, eap});
  endtask

  // Grant cycle, five byte writes, ack cycle; requests held as given throughout.
  task automatic add_frame(input logic rs, input logic rp, input logic pad, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                           input logic [7:0] b4);
    add_tx(rs, rp, 0, 0, 8'h00, 0, 0);
    add_tx(rs, rp, 0, 1, b0, 0, 0);
    add_tx(rs, rp, 0, 1, b1, 0, 0);
    add_tx(rs, rp, 0, 1, b2, 0, 0);
    add_tx(rs, rp, 0, 1, b3, 0, 0);
    add_tx(rs, rp, 0, 1, b4, 0, 0);
    add_tx(rs, rp, 0, 0, 8'h00, !pad, pad);
  endtask

  task automatic add_rx(input logic emp, input logic [7:0] dat, input logic ev,
                        input logic [7:0] eid, input logic [15:0] epay, input logic [7:0] eerr);
    rx_tab.push_back('{emp, dat, !emp, ev, eid, epay, eerr});
  endtask

  task automatic add_rx_idle(input int n, input logic [7:0] eid, input logic [15:0] epay,
                             input logic [7:0] eerr);
    for (int i = 0; i < n; i++) add_rx(1, 8'h00, 0, eid, epay, eerr);
  endtask

  task automatic rx_feed(input logic [7:0] b);
    @(negedge clk);
    rx_empty = 1'b0; rd_data = b;
  endtask

  initial begin
    // TX: score = 0305 -> A5 01 03 05 07, paddle = 1234 -> A5 02 12 34 24
    add_frame(1, 1, 0, 8'hA5, 8'h01, 8'h03, 8'h05, 8'h07);
    add_frame(0, 1, 1, 8'hA5, 8'h02, 8'h12, 8'h34, 8'h24);
    add_frame(1, 0, 0, 8'hA5, 8'h01, 8'h03, 8'h05, 8'h07);
    add_tx(0, 0, 0, 0, 8'h00, 0, 0);
    add_frame(1, 1, 1, 8'hA5, 8'h02, 8'h12, 8'h34, 8'h24);
    add_frame(1, 0, 0, 8'hA5, 8'h01, 8'h03, 8'h05, 8'h07);
    add_tx(0, 0, 0, 0, 8'h00, 0, 0);
    add_tx(1, 0, 0, 0, 8'h00, 0, 0);
    add_tx(1, 0, 0, 1, 8'hA5, 0, 0);
    add_tx(1, 0, 0, 1, 8'h01, 0, 0);
    add_tx(1, 0, 0, 1, 8'h03, 0, 0);
    for (int i = 0; i < 10; i++) add_tx(1, 0, 1, 0, 8'h00, 0, 0);
    add_tx(1, 0, 0, 1, 8'h05, 0, 0);
    add_tx(1, 0, 0, 1, 8'h07, 0, 0);
    add_tx(1, 0, 0, 0, 8'h00, 1, 0);
    add_tx(0, 0, 0, 0, 8'h00, 0, 0);
    add_tx(0, 0, 0, 0, 8'h00, 0, 0);

    // RX: good frame behind junk, bad checksum, timeout, then more good frames
    add_rx(0, 8'h00, 0, 8'h00, 16'h0000, 8'd0);
    add_rx(0, 8'hA5, 0, 8'h00, 16'h0000, 8'd0);
    add_rx(0, 8'h02, 0, 8'h00, 16'h0000, 8'd0);
    add_rx(0, 8'h12, 0, 8'h00, 16'h0000, 8'd0);
    add_rx(0, 8'h34, 0, 8'h00, 16'h0000, 8'd0);
    add_rx(0, 8'h24, 0, 8'h00, 16'h0000, 8'd0);
    add_rx(1, 8'h00, 1, 8'h02, 16'h1234, 8'd0);
    add_rx_idle(1, 8'h02, 16'h1234, 8'd0);
    add_rx(0, 8'hA5, 0, 8'h02, 16'h1234, 8'd0);
    add_rx(0, 8'h02, 0, 8'h02, 16'h1234, 8'd0);
    add_rx(0, 8'h12, 0, 8'h02, 16'h1234, 8'd0);
    add_rx(0, 8'h34, 0, 8'h02, 16'h1234, 8'd0);
    add_rx(0, 8'hFF, 0, 8'h02, 16'h1234, 8'd0);
    add_rx_idle(1, 8'h02, 16'h1234, 8'd1);
    add_rx(0, 8'hA5, 0, 8'h02, 16'h1234, 8'd1);
    add_rx(0, 8'h02, 0, 8'h02, 16'h1234, 8'd1);
    add_rx_idle(TO, 8'h02, 16'h1234, 8'd1);
    add_rx_idle(1, 8'h02, 16'h1234, 8'd2);
    add_rx(0, 8'hA5, 0, 8'h02, 16'h1234, 8'd2);
    add_rx(0, 8'h01, 0, 8'h02, 16'h1234, 8'd2);
    add_rx(0, 8'h03, 0, 8'h02, 16'h1234, 8'd2);
    add_rx(0, 8'h05, 0, 8'h02, 16'h1234, 8'd2);
    add_rx(0, 8'h07, 0, 8'h02, 16'h1234, 8'd2);
    add_rx(1, 8'h00, 1, 8'h01, 16'h0305, 8'd2);
    for (int i = 0; i < 5; i++) add_rx(0, 8'hA5, 0, 8'h01, 16'h0305, 8'd2);
    add_rx(1, 8'h00, 1, 8'hA5, 16'hA5A5, 8'd2);
    add_rx(0, 8'hA5, 0, 8'hA5, 16'hA5A5, 8'd2);
    add_rx(0, 8'h02, 0, 8'hA5, 16'hA5A5, 8'd2);
    add_rx_idle(10, 8'hA5, 16'hA5A5, 8'd2);
    add_rx(0, 8'h12, 0, 8'hA5, 16'hA5A5, 8'd2);
    add_rx(0, 8'h34, 0, 8'hA5, 16'hA5A5, 8'd2);
    add_rx(0, 8'h24, 0, 8'hA5, 16'hA5A5, 8'd2);
    add_rx(1, 8'h00, 1, 8'h02, 16'h1234, 8'd2);

    reset_n = 1'b0;
    req_score = 1'b0; req_paddle = 1'b0; tx_full = 1'b0;
    score_data = 16'h0305; paddle_data = 16'h1234;
    rx_empty = 1'b1; rd_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          40'({wr_uart, wr_data, ack_score, ack_paddle, rd_uart, rx_valid, rx_id, rx_payload, err_cnt}), 40'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tx_tab[i])
      tx_cycle("tx_vec", tx_tab[i].rs, tx_tab[i].rp, tx_tab[i].txf, tx_tab[i].ew,
               tx_tab[i].ed, tx_tab[i].eas, tx_tab[i].eap);
    foreach (rx_tab[i])
      rx_cycle("rx_vec", rx_tab[i].emp, rx_tab[i].dat, rx_tab[i].erd, rx_tab[i].ev,
               rx_tab[i].eid, rx_tab[i].epay, rx_tab[i].eerr);

    // Bad frames (checksum 00 expected, FF sent): err_cnt climbs from 2 and sticks at FF.
    for (int k = 1; k <= 300; k++) begin
      rx_feed(8'hA5); rx_feed(8'h00); rx_feed(8'h00); rx_feed(8'h00); rx_feed(8'hFF);
      @(negedge clk);
      rx_empty = 1'b1;
      #1;
      if (k == 252) check("err_before_sat", 40'(err_cnt), 40'hFE);
      if (k == 253) check("err_at_sat", 40'(err_cnt), 40'hFF);
    end
    check("err_saturated", 40'(err_cnt), 40'hFF);

    // Reset in the middle of a score frame, with RX data pending.
    tx_cycle("rst_grant", 1, 0, 0, 0, 8'h00, 0, 0);
    tx_cycle("rst_b0", 1, 0, 0, 1, 8'hA5, 0, 0);
    tx_cycle("rst_b1", 1, 0, 0, 1, 8'h01, 0, 0);
    @(negedge clk);
    rx_empty = 1'b0; rd_data = 8'hA5;
    reset_n = 1'b0;
    req_score = 1'b0;
    #1;
    check("mid_reset_outputs",
          40'({wr_uart, wr_data, ack_score, ack_paddle, rd_uart, rx_valid, rx_id, rx_payload, err_cnt}), 40'd0);
    repeat (2) @(negedge clk);
    rx_empty = 1'b1;
    reset_n = 1'b1;
    tx_cycle("post_rst_grant", 1, 0, 0, 0, 8'h00, 0, 0);
    tx_cycle("post_rst_b0", 1, 0, 0, 1, 8'hA5, 0, 0);
    tx_cycle("post_rst_b1", 1, 0, 0, 1, 8'h01, 0, 0);
    tx_cycle("post_rst_b2", 1, 0, 0, 1, 8'h03, 0, 0);
    tx_cycle("post_rst_b3", 1, 0, 0, 1, 8'h05, 0, 0);
    tx_cycle("post_rst_b4", 1, 0, 0, 1, 8'h07, 0, 0);
    tx_cycle("post_rst_ack", 1, 0, 0, 0, 8'h00, 1, 0);
    tx_cycle("post_rst_idle", 0, 0, 0, 0, 8'h00, 0, 0);
    rx_cycle("post_rst_rx", 1, 8'h00, 0, 0, 8'h00, 16'h0000, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
